// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, datapath
// select codes, ALU operations and the supported opcodes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI, S_AUIPC
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction funct fields to an ALU
// operation; also flags shift encodings, which this core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [2:0] alu_control,
  output logic       shift_illegal
);

  always_comb begin
    shift_illegal = (funct3 == 3'b001) || (funct3 == 3'b101);
    alu_control   = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type sub from addi, which has no sub form
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath: sequences fetch,
// decode and 1-3 execute/writeback states and drives all enables and selects.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    pc_update, branch, mem_write_s, ir_write_s, reg_write_s, illegal_s;
  logic    shift_illegal, branch_taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .op_b5         (op[5]),
    .alu_control   (alu_control),
    .shift_illegal (shift_illegal)
  );

  always_comb begin
    case (op)
      OP_LW, OP_I, OP_JALR: imm_src = IMM_I;
      OP_SW:                imm_src = IMM_S;
      OP_BRANCH:            imm_src = IMM_B;
      OP_LUI, OP_AUIPC:     imm_src = IMM_U;
      OP_JAL:               imm_src = IMM_J;
      default:              imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         begin state_d = shift_illegal ? S_FETCH : S_EXECR; illegal_s = shift_illegal; end
          OP_I:         begin state_d = shift_illegal ? S_FETCH : S_EXECI; illegal_s = shift_illegal; end
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_LUI:       state_d = S_LUI;
          OP_AUIPC:     state_d = S_AUIPC;
          default:      begin state_d = S_FETCH; illegal_s = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  begin adr_src = 1'b1; state_d = S_MEMWB; end
      S_MEMWB:    begin result_src = RES_MDR; reg_write_s = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write_s = 1'b1; end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
        state_d    = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only beq/bne exist; other branch funct3 values never redirect the PC.
  assign branch_taken  = branch && (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
  assign pc_write      = !reset && (pc_update || branch_taken);
  assign mem_write     = !reset && mem_write_s;
  assign ir_write      = !reset && ir_write_s;
  assign reg_write     = !reset && reg_write_s;
  assign illegal_instr = !reset && illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench: stimulus queues hand-computed per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  typedef struct {
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .reg_write(reg_write), .illegal_instr(illegal_instr)
  );

  // Bit order: pcw adr mw irw rs[2] a[2] b[2] ac[3] imm[3] rw ill
  function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] ac, input logic [2:0] imm,
                                     input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, ac, imm, rw, ill};
  endfunction

  logic [17:0] act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, illegal_instr};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b (pcw adr mw irw rs a b ac imm rw ill)",
                 e.name, act, e.v);
      end
    end
  end

  task automatic step(input logic [17:0] v, input string name);
    exp_t e;
    e.v = v;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic fetch_decode(input logic [2:0] imm, input logic ill, input string name);
    step(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0), {name, "_fetch"});
    step(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill), {name, "_decode"});
  endtask

  task automatic aluwb(input logic [2:0] imm, input string name);
    step(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0), {name, "_aluwb"});
  endtask

  initial begin
    reset = 1'b1;
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    // Reset state: FETCH with all enables suppressed
    step(mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0), "reset_fetch");
    reset = 1'b0;

    // sw, aborted by reset in MEMWRITE
    fetch_decode(3'b001, 0, "sw");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0), "sw_memadr");
    reset = 1'b1;
    step(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0), "sw_memwrite_in_reset");
    step(mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0, 0), "reset_hold_fetch");
    reset = 1'b0;

    // full sw
    fetch_decode(3'b001, 0, "sw2");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0), "sw2_memadr");
    step(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0, 0), "sw2_memwrite");

    // lw
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    fetch_decode(3'b000, 0, "lw");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0), "lw_memadr");
    step(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), "lw_memread");
    step(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0), "lw_memwb");

    // R-type sub
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
    fetch_decode(3'b000, 0, "sub");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0), "sub_execr");
    aluwb(3'b000, "sub");

    // addi with funct7b5 set still adds
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    fetch_decode(3'b000, 0, "addi");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0), "addi_execi");
    aluwb(3'b000, "addi");

    // R-type and, slti, xori
    set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
    fetch_decode(3'b000, 0, "and");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0, 0), "and_execr");
    aluwb(3'b000, "and");
    set_in(7'b0010011, 3'b010, 1'b0, 1'b0);
    fetch_decode(3'b000, 0, "slti");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 3'b000, 0, 0), "slti_execi");
    aluwb(3'b000, "slti");
    set_in(7'b0010011, 3'b100, 1'b0, 1'b0);
    fetch_decode(3'b000, 0, "xori");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000, 0, 0), "xori_execi");
    aluwb(3'b000, "xori");

    // beq taken / not taken, bne taken
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
    fetch_decode(3'b010, 0, "beq_t");
    step(mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0), "beq_t_branch");
    set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b010, 0, "beq_nt");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0), "beq_nt_branch");
    set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
    fetch_decode(3'b010, 0, "bne_t");
    step(mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0), "bne_t_branch");
    // blt encoding is never taken
    set_in(7'b1100011, 3'b100, 1'b0, 1'b1);
    fetch_decode(3'b010, 0, "blt");
    step(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0, 0), "blt_branch");

    // jal
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b100, 0, "jal");
    step(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 0, 0), "jal_jal");
    aluwb(3'b100, "jal");

    // jalr
    set_in(7'b1100111, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b000, 0, "jalr");
    step(mk(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0), "jalr_jalr");
    step(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0), "jalr_link");
    aluwb(3'b000, "jalr");

    // lui, auipc
    set_in(7'b0110111, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b011, 0, "lui");
    step(mk(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b011, 0, 0), "lui_lui");
    aluwb(3'b011, "lui");
    set_in(7'b0010111, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b011, 0, "auipc");
    step(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0, 0), "auipc_auipc");
    aluwb(3'b011, "auipc");

    // illegal: unknown opcode, then slli (shift unsupported), then srai R-type
    set_in(7'b0000000, 3'b000, 1'b0, 1'b0);
    fetch_decode(3'b000, 1, "ill_op");
    set_in(7'b0010011, 3'b001, 1'b0, 1'b0);
    fetch_decode(3'b000, 1, "ill_slli");
    set_in(7'b0110011, 3'b101, 1'b1, 1'b0);
    fetch_decode(3'b000, 1, "ill_sra");
    // next instruction starts in FETCH right after the illegal decode
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    step(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0), "after_ill_fetch");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM of the multicycle RV32I datapath. Sits upstream of the immediate extender, ALU and datapath muxes, and consumes the instruction-register fields. Each instruction is sequenced as fetch, decode, then 1–3 execute/writeback states. The block drives the extender's imm_src, ALU operation, mux selects and all architectural write enables.

Parameters:
none (encodings are fixed in the shared package)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0 (combinational from ALU)
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 = PC, 1 = result
mem_write  out  1  data memory write enable
ir_write  out  1  instruction/old-PC register enable
result_src  out  2  00 = alu_out register, 01 = memory data register, 10 = alu_result (combinational)
alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rd1 register, 11 = constant 0
alu_src_b  out  2  00 = rd2 register, 01 = imm_ext, 10 = constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J (every code distinct)
reg_write  out  1  register-file write enable
illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported encoding

Behaviour:
- Moore FSM. Outputs are a function of state only, except imm_src (from op), alu_control (alu_op plus funct fields) and pc_write (uses zero).
- Reset: at the next rising edge with reset high, state <= FETCH. While reset is high, pc_write, ir_write, reg_write, mem_write and illegal_instr are forced to 0 regardless of state. Reset mid-instruction aborts it; no partial write occurs after the reset edge. The first cycle after reset deasserts is FETCH.
- Outputs not listed for a state: enables = 0, selects = 00, alu_op = add.
- imm_src, decoded from op in every state:
  - lw, I-ALU, jalr -> I
  - sw -> S
  - branch -> B
  - lui, auipc -> U
  - jal -> J
  - other opcodes -> 000
- alu_op per state is add, sub, or funct. Funct decode on funct3:
  - 000: sub if op[5] & funct7b5, else add
  - 010: slt
  - 011: sltu
  - 100: xor
  - 110: or
  - 111: and
- pc_write = pc_update | (branch & (zero ^ funct3[0])). Only beq (000) and bne (001) are supported; other branch funct3 values are never taken.
- States, their outputs, and next state:
  - FETCH: adr_src 0, ir_write, a=00, b=10, add, result_src 10, pc_update -> DECODE
  - DECODE: a=01, b=01, add (branch target into alu_out). Next state by opcode: lw/sw -> MEMADR, R -> EXECR, I-ALU -> EXECI, branch -> BRANCH, jal -> JAL, jalr -> JALR, lui -> LUI, auipc -> AUIPC, illegal -> FETCH with illegal_instr=1
  - MEMADR: a=10, b=01, add -> MEMREAD (lw) or MEMWRITE (sw)
  - MEMREAD: result_src 00, adr_src 1 -> MEMWB
  - MEMWB: result_src 01, reg_write -> FETCH
  - MEMWRITE: result_src 00, adr_src 1, mem_write -> FETCH
  - EXECR: a=10, b=00, funct -> ALUWB
  - EXECI: a=10, b=01, funct -> ALUWB
  - ALUWB: result_src 00, reg_write -> FETCH
  - BRANCH: a=10, b=00, sub, result_src 00, branch -> FETCH
  - JAL: a=01, b=10, add, result_src 00, pc_update -> ALUWB
  - JALR: a=10, b=01, add, result_src 10, pc_update -> JALRLINK
  - JALRLINK: a=01, b=10, add -> ALUWB
  - LUI: a=11, b=01, add -> ALUWB
  - AUIPC: a=01, b=01, add -> ALUWB
- Illegal encodings: unknown opcode, or R/I-ALU with funct3 001/101 (shifts are unsupported).
- CPI: lw 5; sw, R, I, lui, auipc, jal 4; branch 3; jalr 5; illegal 2.
- Unreachable state encodings go to FETCH.

Decomposition:
- Package ctrl_pkg holds: state enum; imm_src, alu_control, alu_op, result_src, alu_src_a/b constants; opcode localparams.
- Sub-module alu_decoder: combinational, takes alu_op, funct3, funct7b5, op[5]; outputs alu_control and a shift/illegal flag.
- Main FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset held for 2 cycles during MEMWRITE of sw -> mem_write=0 while reset is high; state FETCH with ir_write=1 in the first cycle after release.
- lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; imm_src=000; reg_write=1 only in cycle 5; result_src=01 in cycle 5.
- R-type sub (op 0110011, f3 000, f7b5 1) -> alu_control=001 in EXECR; ALUWB reg_write=1; 4 cycles. The same fields with op 0010011 -> alu_control=000.
- beq with zero=1 -> pc_write=1 in BRANCH. beq with zero=0 -> pc_write=0. bne with zero=0 -> pc_write=1. imm_src=010 in all three cases.
- jal (op 1101111) -> imm_src=100; pc_write in JAL; reg_write in ALUWB. jalr -> pc_write with result_src=10 in JALR, then JALRLINK, then ALUWB.
- op 0000000, or op 0010011 with f3 001 -> illegal_instr=1 for exactly the DECODE cycle; next state FETCH; no write enables asserted.
